exception_controller: RTL and testbench

EXCEPTION_CONTROLLER -- requirements
Module: exception_controller

---
 rtl/exception_controller.sv | 253 +++++++++++++++++++++++++
 tb/tb_exception_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exception_controller.sv
// ---------------------------------------------------------------------------
// exception_controller
//
// Purpose:
//   Decides when the pipeline takes an exception or an interrupt, and drives
//   the flush, stall and vector controls that go with it. Synchronous
//   exceptions come from the E stage. Data aborts come from the M stage and
//   take two cycles. FIQ and IRQ sources are first pending-latched. The
//   pipeline is then drained with a marker, which is seen in the D stage and
//   later in the M stage, before the vector is taken.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   UndefinedInstrE, SWIE,
//   PrefetchAbortE                  synchronous exceptions seen in E
//   DataAbort                       data abort seen in M
//   IrqReq[NUM_SRC]                 raw interrupt source lines
//   IrqEnMask[NUM_SRC]              per-source enable
//   IrqClear[NUM_SRC]               write-1-clear for edge pending bits
//   IRQEnabled, FIQEnabled          CPSR class enables
//   PipelineClearD, PipelineClearM  drain marker present in D / M
//   PipelineClearF                  inject drain marker at fetch
//   ExceptionFlushD/E/M/W           per-stage flush
//   ExceptionStallD                 hold D
//   IRQAssert, FIQAssert            interrupt vector taken this cycle
//   DataAbortCycle2                 second cycle of a data abort
//   ExceptionSavePC                 save the return PC (OR of vector bits)
//   PCInSelect                      PC input mux select for exception entry
//   ExceptionResetMicrop            reset the micro-op sequencer
//   Busy                            drain / take / abort2 in progress
//   PCVectorAddress[6:0]            one-hot {FIQ,IRQ,DAbt2,PAbt,SWI,Undef,Reset}
//   IrqId[ID_W]                     index of the last interrupt source taken
//   IrqPending[NUM_SRC]             pending bits, per source
// ---------------------------------------------------------------------------
module exception_controller #(
    parameter int                   NUM_SRC   = 8,
    parameter logic [NUM_SRC-1:0]   FIQ_MASK  = 8'h01,
    parameter logic [NUM_SRC-1:0]   EDGE_MASK = 8'h00,
    localparam int                  ID_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                UndefinedInstrE,
    input  logic                SWIE,
    input  logic                PrefetchAbortE,
    input  logic                DataAbort,
    input  logic [NUM_SRC-1:0]  IrqReq,
    input  logic [NUM_SRC-1:0]  IrqEnMask,
    input  logic [NUM_SRC-1:0]  IrqClear,
    input  logic                IRQEnabled,
    input  logic                FIQEnabled,
    input  logic                PipelineClearD,
    input  logic                PipelineClearM,
    output logic                PipelineClearF,
    output logic                ExceptionFlushD,
    output logic                ExceptionFlushE,
    output logic                ExceptionFlushM,
    output logic                ExceptionFlushW,
    output logic                ExceptionStallD,
    output logic                IRQAssert,
    output logic                FIQAssert,
    output logic                DataAbortCycle2,
    output logic                ExceptionSavePC,
    output logic                PCInSelect,
    output logic                ExceptionResetMicrop,
    output logic                Busy,
    output logic [6:0]          PCVectorAddress,
    output logic [ID_W-1:0]     IrqId,
    output logic [NUM_SRC-1:0]  IrqPending
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        TAKE   = 2'd2,
        ABORT2 = 2'd3
    } state_t;

    // One-hot vector bit positions
    localparam int V_RESET = 0;
    localparam int V_UNDEF = 1;
    localparam int V_SWI   = 2;
    localparam int V_PABT  = 3;
    localparam int V_DABT2 = 4;
    localparam int V_IRQ   = 5;
    localparam int V_FIQ   = 6;

    state_t               state_reg, state_next;
    logic [NUM_SRC-1:0]   pend_reg, pend_next;
    logic [NUM_SRC-1:0]   hist_reg;
    logic [ID_W-1:0]      id_reg;

    // ---------------------------------------------------------------
    // Pending bits. A level source simply follows its line one cycle late.
    // An edge source latches on a rising edge and holds until it is
    // cleared. A new edge wins over a clear in the same cycle, so an event
    // that arrives together with a clear is not lost.
    // ---------------------------------------------------------------
    logic [NUM_SRC-1:0] rise;
    assign rise = IrqReq & ~hist_reg;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign pend_next[gi] = EDGE_MASK[gi]
                                 ? (rise[gi] | (pend_reg[gi] & ~IrqClear[gi]))
                                 : IrqReq[gi];
        end
    endgenerate

    // ---------------------------------------------------------------
    // Eligibility and arbitration
    // ---------------------------------------------------------------
    logic [NUM_SRC-1:0] fiq_vec, irq_vec, win_vec;
    logic               fiq_elig, irq_elig, any_elig;
    logic [ID_W-1:0]    win_id;

    assign fiq_vec  = pend_reg & IrqEnMask &  FIQ_MASK;
    assign irq_vec  = pend_reg & IrqEnMask & ~FIQ_MASK;
    assign fiq_elig = (|fiq_vec) & FIQEnabled;
    assign irq_elig = (|irq_vec) & IRQEnabled;
    assign any_elig = fiq_elig | irq_elig;
    assign win_vec  = fiq_elig ? fiq_vec : irq_vec;

    // Lowest set index wins: scan from the top so lower bits overwrite.
    always_comb begin
        win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (win_vec[i]) begin
                win_id = ID_W'(i);
            end
        end
    end

    logic sync_e;
    assign sync_e = UndefinedInstrE | SWIE | PrefetchAbortE;

    // ---------------------------------------------------------------
    // Control decode: combinational from state and inputs, so that every
    // flush and vector acts in the cycle the event is seen.
    // ---------------------------------------------------------------
    logic       take_fire;
    logic [6:0] vec;

    always_comb begin
        state_next           = state_reg;
        vec                  = '0;
        take_fire            = 1'b0;
        PipelineClearF       = 1'b0;
        ExceptionFlushD      = 1'b0;
        ExceptionFlushE      = 1'b0;
        ExceptionFlushM      = 1'b0;
        ExceptionFlushW      = 1'b0;
        ExceptionStallD      = 1'b0;
        IRQAssert            = 1'b0;
        FIQAssert            = 1'b0;
        DataAbortCycle2      = 1'b0;
        PCInSelect           = 1'b0;
        ExceptionResetMicrop = 1'b0;

        if (reset) begin
            state_next   = IDLE;
            vec[V_RESET] = 1'b1;
        end else if (DataAbort) begin
            // Abort first cycle: wipe everything and restart the micro-op
            // sequencer. The vector is issued in the next cycle.
            ExceptionFlushD      = 1'b1;
            ExceptionFlushE      = 1'b1;
            ExceptionFlushM      = 1'b1;
            ExceptionFlushW      = 1'b1;
            ExceptionStallD      = 1'b1;
            ExceptionResetMicrop = 1'b1;
            state_next           = ABORT2;
        end else if (state_reg == ABORT2) begin
            // E is left alone here. It already holds the cycle-1 bubble.
            DataAbortCycle2 = 1'b1;
            ExceptionFlushD = 1'b1;
            ExceptionFlushM = 1'b1;
            ExceptionFlushW = 1'b1;
            PCInSelect      = 1'b1;
            vec[V_DABT2]    = 1'b1;
            state_next      = IDLE;
        end else if (sync_e) begin
            // An E-stage exception pre-empts any drain in progress. The
            // interrupt stays pending and is re-arbitrated from IDLE.
            ExceptionFlushD = 1'b1;
            ExceptionFlushM = 1'b1;
            PCInSelect      = 1'b1;
            if (PrefetchAbortE)       vec[V_PABT]  = 1'b1;
            else if (UndefinedInstrE) vec[V_UNDEF] = 1'b1;
            else                      vec[V_SWI]   = 1'b1;
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (any_elig) state_next = DRAIN;
                end
                DRAIN: begin
                    if (!any_elig) begin
                        state_next = IDLE;
                    end else begin
                        PipelineClearF = ~PipelineClearM;
                        // The marker is in D but has not reached M. Squash
                        // what follows it so that nothing new enters E.
                        if (PipelineClearD && !PipelineClearM) begin
                            ExceptionFlushE = 1'b1;
                            ExceptionStallD = 1'b1;
                        end
                        if (PipelineClearM) state_next = TAKE;
                    end
                end
                TAKE: begin
                    state_next = IDLE;
                    if (any_elig) begin
                        take_fire       = 1'b1;
                        ExceptionFlushD = 1'b1;
                        if (fiq_elig) begin
                            FIQAssert  = 1'b1;
                            vec[V_FIQ] = 1'b1;
                        end else begin
                            IRQAssert  = 1'b1;
                            vec[V_IRQ] = 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign PCVectorAddress = vec;
    assign ExceptionSavePC = |vec;
    assign Busy            = ~reset & (state_reg != IDLE);
    assign IrqId           = take_fire ? win_id : id_reg;
    assign IrqPending      = pend_reg;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            pend_reg  <= '0;
            hist_reg  <= '0;
            id_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
            hist_reg  <= IrqReq;
            if (take_fire) id_reg <= win_id;
        end
    end

endmodule

// File: tb/tb_exception_controller.sv
// ---------------------------------------------------------------------------
// tb_exception_controller
//
// Directed bench for exception_controller. The design uses the default FIQ
// class on source 0, and source 5 is edge-triggered. Inputs change 1 time
// unit after a rising edge. Combinational outputs are sampled 1 time unit
// later, well before the next rising edge.
// ---------------------------------------------------------------------------
module tb_exception_controller;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         UndefinedInstrE, SWIE, PrefetchAbortE, DataAbort;
    logic [N-1:0] IrqReq, IrqEnMask, IrqClear;
    logic         IRQEnabled, FIQEnabled, PipelineClearD, PipelineClearM;
    logic         PipelineClearF, ExceptionFlushD, ExceptionFlushE;
    logic         ExceptionFlushM, ExceptionFlushW, ExceptionStallD;
    logic         IRQAssert, FIQAssert, DataAbortCycle2, ExceptionSavePC;
    logic         PCInSelect, ExceptionResetMicrop, Busy;
    logic [6:0]   PCVectorAddress;
    logic [2:0]   IrqId;
    logic [N-1:0] IrqPending;

    logic [3:0]   flush;
    assign flush = {ExceptionFlushD, ExceptionFlushE, ExceptionFlushM, ExceptionFlushW};

    always #5 clk = ~clk;

    exception_controller #(
        .NUM_SRC   (N),
        .FIQ_MASK  (8'h01),
        .EDGE_MASK (8'h20)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .UndefinedInstrE      (UndefinedInstrE),
        .SWIE                 (SWIE),
        .PrefetchAbortE       (PrefetchAbortE),
        .DataAbort            (DataAbort),
        .IrqReq               (IrqReq),
        .IrqEnMask            (IrqEnMask),
        .IrqClear             (IrqClear),
        .IRQEnabled           (IRQEnabled),
        .FIQEnabled           (FIQEnabled),
        .PipelineClearD       (PipelineClearD),
        .PipelineClearM       (PipelineClearM),
        .PipelineClearF       (PipelineClearF),
        .ExceptionFlushD      (ExceptionFlushD),
        .ExceptionFlushE      (ExceptionFlushE),
        .ExceptionFlushM      (ExceptionFlushM),
        .ExceptionFlushW      (ExceptionFlushW),
        .ExceptionStallD      (ExceptionStallD),
        .IRQAssert            (IRQAssert),
        .FIQAssert            (FIQAssert),
        .DataAbortCycle2      (DataAbortCycle2),
        .ExceptionSavePC      (ExceptionSavePC),
        .PCInSelect           (PCInSelect),
        .ExceptionResetMicrop (ExceptionResetMicrop),
        .Busy                 (Busy),
        .PCVectorAddress      (PCVectorAddress),
        .IrqId                (IrqId),
        .IrqPending           (IrqPending)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        UndefinedInstrE = 0; SWIE = 0; PrefetchAbortE = 0; DataAbort = 0;
        IrqReq = '0; IrqEnMask = 8'hDF; IrqClear = '0;
        IRQEnabled = 1; FIQEnabled = 1; PipelineClearD = 0; PipelineClearM = 0;

        // ---- reset state
        $display("txn reset");
        repeat (2) nxt();
        #1;
        chk("rst_vec",    PCVectorAddress, 7'b0000001);
        chk("rst_save",   ExceptionSavePC, 1'b1);
        chk("rst_busy",   Busy, 1'b0);
        chk("rst_id",     IrqId, 3'd0);
        chk("rst_pend",   IrqPending, 8'h00);
        chk("rst_dac2",   DataAbortCycle2, 1'b0);
        chk("rst_flush",  flush, 4'b0000);
        nxt(); reset = 1'b0; #1;
        chk("idle_vec",   PCVectorAddress, 7'b0000000);
        chk("idle_save",  ExceptionSavePC, 1'b0);

        // ---- level IRQ src3 taken after a full drain
        $display("txn irq3_drain");
        nxt(); IrqReq = 8'h08; #1;
        nxt(); #1;
        chk("a_pend",     IrqPending, 8'h08);
        chk("a_idle_busy", Busy, 1'b0);
        nxt(); #1;
        chk("a_drain_busy", Busy, 1'b1);
        chk("a_pcf",      PipelineClearF, 1'b1);
        nxt(); PipelineClearD = 1; #1;
        chk("a_flushE",   ExceptionFlushE, 1'b1);
        chk("a_stallD",   ExceptionStallD, 1'b1);
        nxt(); PipelineClearD = 0; #1;
        chk("a_flushE_off", ExceptionFlushE, 1'b0);
        nxt(); PipelineClearM = 1; #1;
        chk("a_pcf_m",    PipelineClearF, 1'b0);
        nxt(); PipelineClearM = 0; IrqReq = 8'h00; #1;
        chk("a_irq",      IRQAssert, 1'b1);
        chk("a_fiq",      FIQAssert, 1'b0);
        chk("a_id",       IrqId, 3'd3);
        chk("a_vec",      PCVectorAddress, 7'b0100000);
        chk("a_flushD",   ExceptionFlushD, 1'b1);
        chk("a_save",     ExceptionSavePC, 1'b1);
        chk("a_pcin",     PCInSelect, 1'b0);
        nxt(); #1;
        chk("a_after_busy", Busy, 1'b0);
        chk("a_after_irq", IRQAssert, 1'b0);
        chk("a_id_hold",  IrqId, 3'd3);
        chk("a_pend_clr", IrqPending, 8'h00);

        // ---- FIQ arrives during an IRQ drain and wins at TAKE
        $display("txn fiq_preempts_irq");
        nxt(); IrqReq = 8'h10; #1;
        nxt(); #1;
        nxt(); IrqReq = 8'h11; #1;
        chk("b_busy",     Busy, 1'b1);
        nxt(); PipelineClearM = 1; #1;
        chk("b_pend",     IrqPending, 8'h11);
        nxt(); PipelineClearM = 0; IrqReq = 8'h00; #1;
        chk("b_fiq",      FIQAssert, 1'b1);
        chk("b_irq",      IRQAssert, 1'b0);
        chk("b_id",       IrqId, 3'd0);
        chk("b_vec",      PCVectorAddress, 7'b1000000);
        nxt(); #1;
        chk("b_after_busy", Busy, 1'b0);

        // ---- data abort during a drain, then the drain restarts
        $display("txn dabort_in_drain");
        nxt(); IrqReq = 8'h04; #1;
        nxt(); #1;
        nxt(); DataAbort = 1; #1;
        chk("c_flush",    flush, 4'b1111);
        chk("c_stall",    ExceptionStallD, 1'b1);
        chk("c_microp",   ExceptionResetMicrop, 1'b1);
        chk("c_vec1",     PCVectorAddress, 7'b0000000);
        nxt(); DataAbort = 0; #1;
        chk("c_dac2",     DataAbortCycle2, 1'b1);
        chk("c_vec2",     PCVectorAddress, 7'b0010000);
        chk("c_flush2",   flush, 4'b1011);
        chk("c_stall2",   ExceptionStallD, 1'b0);
        chk("c_pcin",     PCInSelect, 1'b1);
        chk("c_save",     ExceptionSavePC, 1'b1);
        nxt(); #1;
        chk("c_idle",     Busy, 1'b0);
        chk("c_dac2_off", DataAbortCycle2, 1'b0);
        nxt(); #1;
        chk("c_redrain",  Busy, 1'b1);
        chk("c_redrain_pcf", PipelineClearF, 1'b1);
        nxt(); IrqReq = 8'h00; #1;
        nxt(); #1;
        chk("c_noelig_pcf", PipelineClearF, 1'b0);
        chk("c_noelig_flush", flush, 4'b0000);
        nxt(); #1;
        chk("c_back_idle", Busy, 1'b0);
        chk("c_no_irq",   IRQAssert, 1'b0);

        // ---- IRQEnabled dropped mid-drain
        $display("txn irq_disable_in_drain");
        nxt(); IrqReq = 8'h40; #1;
        nxt(); #1;
        nxt(); IRQEnabled = 0; IrqReq = 8'h00; #1;
        chk("d_pcf",      PipelineClearF, 1'b0);
        nxt(); #1;
        chk("d_idle",     Busy, 1'b0);
        chk("d_no_irq",   IRQAssert, 1'b0);
        IRQEnabled = 1;

        // ---- SWI in IDLE with an IRQ pending, then the IRQ is taken
        $display("txn swi_then_irq");
        nxt(); IrqReq = 8'h02; #1;
        nxt(); SWIE = 1; #1;
        chk("e_flush",    flush, 4'b1010);
        chk("e_vec",      PCVectorAddress, 7'b0000100);
        chk("e_pcin",     PCInSelect, 1'b1);
        chk("e_save",     ExceptionSavePC, 1'b1);
        nxt(); SWIE = 0; #1;
        chk("e_idle",     Busy, 1'b0);
        nxt(); PipelineClearM = 1; #1;
        chk("e_drain",    Busy, 1'b1);
        nxt(); PipelineClearM = 0; IrqReq = 8'h00; #1;
        chk("e_irq",      IRQAssert, 1'b1);
        chk("e_id",       IrqId, 3'd1);
        nxt(); #1;

        // ---- other E-stage vectors
        $display("txn sync_vectors");
        nxt(); UndefinedInstrE = 1; #1;
        chk("f_undef",    PCVectorAddress, 7'b0000010);
        nxt(); UndefinedInstrE = 0; PrefetchAbortE = 1; #1;
        chk("f_pabt",     PCVectorAddress, 7'b0001000);
        nxt(); PrefetchAbortE = 0; #1;

        // ---- reset mid-drain abandons the interrupt
        $display("txn reset_mid_drain");
        nxt(); IrqReq = 8'h08; #1;
        nxt(); #1;
        nxt(); reset = 1; IrqReq = 8'h00; #1;
        chk("g_vec",      PCVectorAddress, 7'b0000001);
        chk("g_pcf",      PipelineClearF, 1'b0);
        chk("g_busy",     Busy, 1'b0);
        nxt(); reset = 0; #1;
        chk("g_pend",     IrqPending, 8'h00);
        chk("g_busy2",    Busy, 1'b0);
        chk("g_id",       IrqId, 3'd0);
        nxt(); #1;
        chk("g_no_irq",   IRQAssert, 1'b0);

        // ---- edge source 5: set beats clear, then an explicit clear
        $display("txn edge_src5");
        nxt(); IrqReq = 8'h20; IrqClear = 8'h20; #1;
        nxt(); IrqReq = 8'h00; IrqClear = 8'h00; #1;
        chk("h_set",      IrqPending, 8'h20);
        nxt(); #1;
        chk("h_hold",     IrqPending, 8'h20);
        nxt(); IrqClear = 8'h20; #1;
        nxt(); IrqClear = 8'h00; #1;
        chk("h_clr",      IrqPending, 8'h00);
        nxt(); IrqReq = 8'h20; #1;
        nxt(); IrqClear = 8'h20; #1;
        nxt(); IrqClear = 8'h00; #1;
        chk("h_no_retrig", IrqPending, 8'h00);
        IrqReq = 8'h00;
        nxt(); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
